// File: rtl/nanov_periph_bus.sv
// Memory-mapped peripheral window for nanoV: GPIO with set/clear/toggle, a TX byte
// FIFO draining into uart_tx, UART RX passthrough and a snapshotted cycle counter.
module nanov_periph_bus #(
  parameter logic [31:0]           BASE_ADDR     = 32'h1000_0000,
  parameter int                    GPIO_OUT_W    = 8,
  parameter int                    GPIO_IN_W     = 8,
  parameter logic [GPIO_OUT_W-1:0] GPIO_RESET    = '0,
  parameter int                    TX_FIFO_DEPTH = 4,
  // Start value of the free-running counter; nonzero only to reach the wrap quickly in simulation
  parameter logic [31:0]           CYCLE_RESET   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  addr_valid,
  input  logic                  data_valid,
  input  logic                  data_read,
  input  logic [31:0]           data_out,
  output logic [31:0]           ext_data_in,
  input  logic [GPIO_IN_W-1:0]  gpio_in,
  output logic [GPIO_OUT_W-1:0] gpio_out,
  output logic                  uart_tx_en,
  output logic [7:0]            uart_tx_data,
  input  logic                  uart_tx_busy,
  input  logic [7:0]            uart_rx_data,
  input  logic                  uart_rx_valid,
  output logic                  uart_rx_read
);

  localparam int         PTR_W   = $clog2(TX_FIFO_DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(TX_FIFO_DEPTH);

  typedef enum logic [2:0] {
    SEL_NONE, SEL_GPIO, SEL_SET, SEL_CLR, SEL_TOG, SEL_UDATA, SEL_USTAT, SEL_CYCLE
  } sel_e;

  typedef enum logic {TX_IDLE, TX_WAIT} tx_e;

  function automatic logic [31:0] bit_rev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  sel_e                  r_sel;
  tx_e                   r_state;
  logic                  r_wait_first;
  logic                  r_tx_en;
  logic [7:0]            r_tx_data;
  logic [GPIO_OUT_W-1:0] r_gpio;
  logic [7:0]            r_mem [TX_FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [4:0]            r_count;
  logic                  r_ovf;
  logic [31:0]           r_cycle;
  logic [31:0]           r_snap;

  sel_e                  w_sel_dec;
  logic [31:0]           w_wdata;
  logic [GPIO_OUT_W-1:0] w_wd_g;
  logic                  w_push;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push_ok;
  logic                  w_ovf_set;
  logic                  w_ovf_clr;
  logic                  w_idle;
  logic [7:0]            w_head;
  logic [31:0]           w_status;

  assign w_wdata   = bit_rev(data_out);
  assign w_wd_g    = w_wdata[GPIO_OUT_W-1:0];
  assign w_push    = data_valid && (r_sel == SEL_UDATA);
  assign w_full    = (r_count == DEPTH_C);
  // An empty FIFO forwards the incoming byte straight to the head for one-cycle latency
  assign w_pop     = (r_state == TX_IDLE) && !uart_tx_busy && ((r_count != 5'd0) || w_push);
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_head    = (r_count == 5'd0) ? w_wdata[7:0] : r_mem[r_rptr];
  assign w_ovf_set = w_push && w_full && !w_pop;
  assign w_ovf_clr = data_read && (r_sel == SEL_USTAT);
  assign w_idle    = (r_count == 5'd0) && (r_state == TX_IDLE) && !uart_tx_busy;
  assign w_status  = {19'h0, r_count, 4'h0, r_ovf, w_idle, uart_rx_valid, w_full};

  assign gpio_out     = r_gpio;
  assign uart_tx_en   = r_tx_en;
  assign uart_tx_data = r_tx_data;
  assign uart_rx_read = data_read && (r_sel == SEL_UDATA);

  // Exact-address decode of the strobed address
  always_comb begin
    w_sel_dec = SEL_NONE;
    if (data_out == BASE_ADDR + 32'h00)      w_sel_dec = SEL_GPIO;
    else if (data_out == BASE_ADDR + 32'h04) w_sel_dec = SEL_SET;
    else if (data_out == BASE_ADDR + 32'h08) w_sel_dec = SEL_CLR;
    else if (data_out == BASE_ADDR + 32'h0C) w_sel_dec = SEL_TOG;
    else if (data_out == BASE_ADDR + 32'h10) w_sel_dec = SEL_UDATA;
    else if (data_out == BASE_ADDR + 32'h14) w_sel_dec = SEL_USTAT;
    else if (data_out == BASE_ADDR + 32'h18) w_sel_dec = SEL_CYCLE;
    else                                     w_sel_dec = SEL_NONE;
  end

  // Read mux
  always_comb begin
    ext_data_in = 32'h0;
    case (r_sel)
      SEL_GPIO:  ext_data_in = 32'(gpio_in);
      SEL_UDATA: ext_data_in = {24'h0, uart_rx_data};
      SEL_USTAT: ext_data_in = w_status;
      SEL_CYCLE: ext_data_in = r_snap;
      default:   ext_data_in = 32'h0;
    endcase
  end

  // Register select latch
  always_ff @(posedge clk) begin
    if (rst)             r_sel <= SEL_NONE;
    else if (addr_valid) r_sel <= w_sel_dec;
    else                 r_sel <= r_sel;
  end

  // GPIO output register with atomic set/clear/toggle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpio <= GPIO_RESET;
    end else if (data_valid) begin
      case (r_sel)
        SEL_GPIO: r_gpio <= w_wd_g;
        SEL_SET:  r_gpio <= r_gpio | w_wd_g;
        SEL_CLR:  r_gpio <= r_gpio & ~w_wd_g;
        SEL_TOG:  r_gpio <= r_gpio ^ w_wd_g;
        default:  r_gpio <= r_gpio;
      endcase
    end else begin
      r_gpio <= r_gpio;
    end
  end

  // Free-running counter and the snapshot taken when CYCLE is selected
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle <= CYCLE_RESET;
      r_snap  <= 32'h0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (addr_valid && (w_sel_dec == SEL_CYCLE)) r_snap <= r_cycle;
      else                                        r_snap <= r_snap;
    end
  end

  // FIFO storage; contents need no reset since pointers and count define validity
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= w_wdata[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= 5'd0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)     r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      else                r_ovf <= r_ovf;
    end
  end

  // TX drain FSM; WAIT ignores busy on its entry cycle to cover the UART's busy latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= TX_IDLE;
      r_wait_first <= 1'b0;
      r_tx_en      <= 1'b0;
      r_tx_data    <= 8'h00;
    end else begin
      case (r_state)
        TX_IDLE: begin
          r_wait_first <= 1'b1;
          if (w_pop) begin
            r_tx_en   <= 1'b1;
            r_tx_data <= w_head;
            r_state   <= TX_WAIT;
          end else begin
            r_tx_en <= 1'b0;
          end
        end
        TX_WAIT: begin
          r_tx_en <= 1'b0;
          if (r_wait_first)       r_wait_first <= 1'b0;
          else if (!uart_tx_busy) r_state      <= TX_IDLE;
          else                    r_state      <= TX_WAIT;
        end
        default: begin
          r_state <= TX_IDLE;
          r_tx_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nanov_periph_bus.sv
// Directed bench for nanov_periph_bus: GPIO ops, UART TX FIFO/drain, overflow,
// coherent cycle snapshot across wrap, unmapped addresses and reset mid-transfer.
module tb_nanov_periph_bus;

  localparam logic [31:0] BASE     = 32'h1000_0000;
  localparam logic [31:0] CYC_INIT = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        addr_valid = 1'b0;
  logic        data_valid = 1'b0;
  logic        data_read = 1'b0;
  logic [31:0] data_out = 32'h0;
  logic [31:0] ext_data_in;
  logic [7:0]  gpio_in = 8'h00;
  logic [7:0]  gpio_out;
  logic        uart_tx_en;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_busy;
  logic [7:0]  uart_rx_data = 8'h00;
  logic        uart_rx_valid = 1'b0;
  logic        uart_rx_read;

  int          vectors = 0;
  int          errors = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  logic        hold_busy = 1'b0;
  logic [31:0] exp_cyc = 32'h0;
  logic [7:0]  tx_q[$];
  int          tx_t[$];

  nanov_periph_bus #(
    .BASE_ADDR(BASE), .GPIO_OUT_W(8), .GPIO_IN_W(8), .GPIO_RESET(8'h5A),
    .TX_FIFO_DEPTH(4), .CYCLE_RESET(CYC_INIT)
  ) dut (
    .clk(clk), .rst(rst), .addr_valid(addr_valid), .data_valid(data_valid),
    .data_read(data_read), .data_out(data_out), .ext_data_in(ext_data_in),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .uart_tx_en(uart_tx_en),
    .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_read(uart_rx_read)
  );

  always #5 clk = ~clk;

  // UART model: busy for 20 cycles after each start pulse, or held by a test
  assign uart_tx_busy = hold_busy || (busy_cnt != 0);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    exp_cyc <= rst ? CYC_INIT : exp_cyc + 32'd1;
    if (uart_tx_en) busy_cnt <= 20;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  always @(negedge clk) begin
    if (uart_tx_en) begin
      tx_q.push_back(uart_tx_data);
      tx_t.push_back(cyc);
    end
  end

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = v[i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sel_addr(input logic [31:0] off);
    addr_valid = 1'b1; data_out = BASE + off;
    step();
    addr_valid = 1'b0; data_out = 32'h0;
    #1;
  endtask

  task automatic wr(input logic [31:0] d);
    data_valid = 1'b1; data_out = rev32(d);
    step();
    data_valid = 1'b0; data_out = 32'h0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    tx_q.delete(); tx_t.delete();
    repeat (10) step();
    vectors++; if (gpio_out !== 8'h5A) begin errors++; $display("FAIL reset_gpio: got %h want %h", gpio_out, 8'h5A); end
    vectors++; if (tx_q.size() !== 0) begin errors++; $display("FAIL reset_no_tx: got %0d pulses want 0", tx_q.size()); end
    sel_addr(32'h14);
    vectors++; if (ext_data_in !== 32'h4) begin errors++; $display("FAIL reset_status: got %h want %h", ext_data_in, 32'h4); end
  endtask

  task automatic test_gpio();
    sel_addr(32'h00); wr(32'hA5);
    vectors++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL gpio_write: got %h want %h", gpio_out, 8'hA5); end
    sel_addr(32'h04); wr(32'h0F);
    vectors++; if (gpio_out !== 8'hAF) begin errors++; $display("FAIL gpio_set: got %h want %h", gpio_out, 8'hAF); end
    sel_addr(32'h08); wr(32'hA0);
    vectors++; if (gpio_out !== 8'h0F) begin errors++; $display("FAIL gpio_clr: got %h want %h", gpio_out, 8'h0F); end
    sel_addr(32'h0C); wr(32'hFF);
    vectors++; if (gpio_out !== 8'hF0) begin errors++; $display("FAIL gpio_tog: got %h want %h", gpio_out, 8'hF0); end
    gpio_in = 8'h3C; #1;
    vectors++; if (ext_data_in !== 32'h0) begin errors++; $display("FAIL gpio_tog_read: got %h want %h", ext_data_in, 32'h0); end
    sel_addr(32'h00);
    vectors++; if (ext_data_in !== 32'h3C) begin errors++; $display("FAIL gpio_read: got %h want %h", ext_data_in, 32'h3C); end
    wr(32'h1234_5678);
    vectors++; if (gpio_out !== 8'h78) begin errors++; $display("FAIL gpio_trunc: got %h want %h", gpio_out, 8'h78); end
    wr(32'hF0);
  endtask

  task automatic test_uart_rx();
    uart_rx_data = 8'hC3; uart_rx_valid = 1'b1;
    sel_addr(32'h10);
    vectors++; if (ext_data_in !== 32'hC3) begin errors++; $display("FAIL rx_data: got %h want %h", ext_data_in, 32'hC3); end
    data_read = 1'b1; #1;
    vectors++; if (uart_rx_read !== 1'b1) begin errors++; $display("FAIL rx_read_on: got %b want 1", uart_rx_read); end
    data_read = 1'b0; #1;
    vectors++; if (uart_rx_read !== 1'b0) begin errors++; $display("FAIL rx_read_off: got %b want 0", uart_rx_read); end
    sel_addr(32'h14);
    vectors++; if (ext_data_in !== 32'h6) begin errors++; $display("FAIL rx_status: got %h want %h", ext_data_in, 32'h6); end
    uart_rx_valid = 1'b0;
  endtask

  task automatic test_uart_tx();
    int n;
    tx_q.delete(); tx_t.delete();
    sel_addr(32'h10);
    data_valid = 1'b1; data_out = rev32(32'h41);
    step();
    vectors++; if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'h41) begin errors++; $display("FAIL tx_latency: got en=%b data=%h want en=1 data=41", uart_tx_en, uart_tx_data); end
    data_out = rev32(32'h42); step();
    data_out = rev32(32'h43); step();
    data_valid = 1'b0; data_out = 32'h0;
    n = 0;
    while (tx_q.size() < 3 && n < 300) begin step(); n++; end
    vectors++; if (tx_q.size() !== 3) begin errors++; $display("FAIL tx_count: got %0d want 3", tx_q.size()); end
    if (tx_q.size() == 3) begin
      vectors++; if (tx_q[0] !== 8'h41 || tx_q[1] !== 8'h42 || tx_q[2] !== 8'h43) begin errors++; $display("FAIL tx_order: got %h %h %h want 41 42 43", tx_q[0], tx_q[1], tx_q[2]); end
      vectors++; if (tx_t[1] - tx_t[0] < 21 || tx_t[2] - tx_t[1] < 21) begin errors++; $display("FAIL tx_spacing: got %0d %0d want >=21", tx_t[1] - tx_t[0], tx_t[2] - tx_t[1]); end
    end
    repeat (30) step();
    sel_addr(32'h14);
    vectors++; if (ext_data_in !== 32'h4) begin errors++; $display("FAIL tx_idle_status: got %h want %h", ext_data_in, 32'h4); end
  endtask

  task automatic test_overflow();
    int n;
    hold_busy = 1'b1;
    tx_q.delete(); tx_t.delete();
    sel_addr(32'h10);
    for (int i = 0; i < 5; i++) wr(32'h61 + i);
    sel_addr(32'h14);
    vectors++; if (ext_data_in !== 32'h409) begin errors++; $display("FAIL ovf_status: got %h want %h", ext_data_in, 32'h409); end
    data_read = 1'b1; step(); data_read = 1'b0; #1;
    vectors++; if (ext_data_in !== 32'h401) begin errors++; $display("FAIL ovf_clear: got %h want %h", ext_data_in, 32'h401); end
    // full FIFO: pop and push land on the same edge
    sel_addr(32'h10);
    hold_busy = 1'b0;
    wr(32'h66);
    sel_addr(32'h14);
    vectors++; if (ext_data_in !== 32'h401) begin errors++; $display("FAIL full_push_pop: got %h want %h", ext_data_in, 32'h401); end
    n = 0;
    while (tx_q.size() < 5 && n < 600) begin step(); n++; end
    repeat (30) step();
    vectors++; if (tx_q.size() !== 5) begin errors++; $display("FAIL ovf_drain_count: got %0d want 5", tx_q.size()); end
    if (tx_q.size() == 5) begin
      vectors++; if (tx_q[0] !== 8'h61 || tx_q[1] !== 8'h62 || tx_q[2] !== 8'h63 || tx_q[3] !== 8'h64 || tx_q[4] !== 8'h66) begin
        errors++; $display("FAIL ovf_drain_data: got %h %h %h %h %h want 61 62 63 64 66", tx_q[0], tx_q[1], tx_q[2], tx_q[3], tx_q[4]);
      end
    end
  endtask

  task automatic test_cycle();
    int n;
    logic [31:0] e;
    rst = 1'b1; step(); rst = 1'b0;
    n = 0;
    while (exp_cyc != 32'hFFFF_FFFE && n < 1000) begin step(); n++; end
    vectors++; if (exp_cyc !== 32'hFFFF_FFFE) begin errors++; $display("FAIL cyc_reach: got %h want fffffffe", exp_cyc); end
    sel_addr(32'h18);
    data_read = 1'b1;
    for (int i = 0; i < 32; i++) begin
      vectors++; if (ext_data_in !== 32'hFFFF_FFFE) begin errors++; $display("FAIL cyc_hold[%0d]: got %h want fffffffe", i, ext_data_in); end
      step();
    end
    data_read = 1'b0;
    e = exp_cyc;
    sel_addr(32'h18);
    vectors++; if (ext_data_in !== e) begin errors++; $display("FAIL cyc_wrapped: got %h want %h", ext_data_in, e); end
  endtask

  task automatic test_unmapped();
    sel_addr(32'h20);
    vectors++; if (ext_data_in !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h want 0", ext_data_in); end
    wr(32'hFF);
    vectors++; if (gpio_out !== 8'h5A) begin errors++; $display("FAIL unmapped_write: got %h want %h", gpio_out, 8'h5A); end
    sel_addr(32'h01);
    vectors++; if (ext_data_in !== 32'h0) begin errors++; $display("FAIL misaligned_read: got %h want 0", ext_data_in); end
    sel_addr(32'h14);
    vectors++; if (ext_data_in !== 32'h4) begin errors++; $display("FAIL unmapped_fifo: got %h want %h", ext_data_in, 32'h4); end
  endtask

  task automatic test_reset_flight();
    hold_busy = 1'b1;
    sel_addr(32'h10); wr(32'h71); wr(32'h72);
    sel_addr(32'h14);
    vectors++; if (ext_data_in !== 32'h200) begin errors++; $display("FAIL flight_count: got %h want %h", ext_data_in, 32'h200); end
    rst = 1'b1; step(); rst = 1'b0;
    hold_busy = 1'b0;
    tx_q.delete(); tx_t.delete();
    repeat (50) step();
    vectors++; if (tx_q.size() !== 0) begin errors++; $display("FAIL flight_no_tx: got %0d pulses want 0", tx_q.size()); end
    sel_addr(32'h14);
    vectors++; if (ext_data_in !== 32'h4) begin errors++; $display("FAIL flight_status: got %h want %h", ext_data_in, 32'h4); end
  endtask

  initial begin
    test_reset();
    test_gpio();
    test_uart_rx();
    test_uart_tx();
    test_overflow();
    test_cycle();
    test_unmapped();
    test_reset_flight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
